// File: rtl/keccak_padder_pkg.sv
// rtl/keccak_padder_pkg.sv - shared constants and types for the keccak message padder
package pkg_keccak;

  localparam int IN_BUF_SIZE = 32;
  localparam int RATE_WORDS  = 34;
  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    PADBLK
  } padder_state_t;

endpackage

// File: rtl/keccak_padder_if.sv
// rtl/keccak_padder_if.sv - message stream in and padded word stream out of the padder
interface keccak_padder_if;
  import pkg_keccak::*;

  logic [31:0]            msg_word;
  logic                   msg_valid;
  logic                   msg_last;
  logic [2:0]             msg_nbytes;
  logic                   msg_ready;
  logic [IN_BUF_SIZE-1:0] din;
  logic                   din_valid;
  logic                   last_block;
  logic                   buffer_full;

  modport slave (
    input  msg_word, msg_valid, msg_last, msg_nbytes, buffer_full,
    output msg_ready, din, din_valid, last_block
  );

  modport master (
    output msg_word, msg_valid, msg_last, msg_nbytes, buffer_full,
    input  msg_ready, din, din_valid, last_block
  );
endinterface

// File: rtl/keccak_pad_word.sv
// rtl/keccak_pad_word.sv - applies pad10*1 to one word of the block that holds the message end
module keccak_pad_word
  import pkg_keccak::*;
#(
  parameter int RATE_WORDS = pkg_keccak::RATE_WORDS,
  localparam int CW = $clog2(RATE_WORDS) + 1
) (
  input  logic [31:0]   word,
  input  logic [CW-1:0] idx,
  input  logic [CW-1:0] last_idx,
  input  logic [2:0]    last_nb,
  input  logic          has_last,
  output logic [31:0]   padded
);

  localparam logic [CW-1:0] LAST_W = CW'(RATE_WORDS - 1);

  always_comb begin
    padded = word;
    if (has_last) begin
      if (idx == last_idx) begin
        for (int b = 0; b < 4; b++) begin
          if (3'(b) == last_nb)
            padded[8*b +: 8] = PAD_FIRST;
          else if (3'(b) > last_nb)
            padded[8*b +: 8] = 8'h00;
        end
      end else if (idx > last_idx) begin
        padded = '0;
        // A full final word pushes the leading pad bit into the next word.
        if (last_nb == 3'd4 && idx == last_idx + CW'(1))
          padded[7:0] = PAD_FIRST;
      end
      if (idx == LAST_W)
        padded[31:24] = padded[31:24] | PAD_LAST;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// rtl/keccak_padder.sv - buffers one rate block of message words and streams it padded into keccak
module keccak_padder
  import pkg_keccak::*;
#(
  parameter int RATE_WORDS = pkg_keccak::RATE_WORDS
) (
  input  logic            clock,
  input  logic            reset,
  keccak_padder_if.slave  bus,
  output logic            busy
);

  localparam int CW = $clog2(RATE_WORDS) + 1;
  localparam int AW = $clog2(RATE_WORDS);
  localparam logic [CW-1:0] LAST_W = CW'(RATE_WORDS - 1);

  padder_state_t state;
  logic [CW-1:0] wcnt, didx, last_idx;
  logic [2:0]    last_nb;
  logic          blk_last, need_pad_blk;
  logic [31:0]   blk_buf [RATE_WORDS];

  logic [2:0]    nb_cl;
  logic          accept, closing, pad_exc, xfer;
  logic [CW-1:0] nidx;
  logic [31:0]   pw_word, pw_out;
  logic [CW-1:0] pw_idx, pw_last_idx;
  logic [2:0]    pw_last_nb;
  logic          pw_has;

  assign nb_cl   = (bus.msg_nbytes > 3'd4) ? 3'd4 : bus.msg_nbytes;
  assign accept  = bus.msg_valid && bus.msg_ready;
  assign closing = accept && (bus.msg_last || wcnt == LAST_W);
  assign pad_exc = bus.msg_last && (wcnt == LAST_W) && (nb_cl == 3'd4);
  assign xfer    = bus.din_valid && !bus.buffer_full;
  assign nidx    = (didx == LAST_W) ? '0 : didx + CW'(1);
  assign busy    = (state != FILL) || (wcnt != '0);

  // While filling, the pad word is word 0 of the block being closed so it can
  // be presented on the same edge that captures the closing word.
  always_comb begin
    pw_word     = blk_buf[nidx[AW-1:0]];
    pw_idx      = nidx;
    pw_last_idx = last_idx;
    pw_last_nb  = last_nb;
    pw_has      = blk_last;
    if (state == FILL) begin
      pw_word     = (wcnt == '0) ? bus.msg_word : blk_buf[0];
      pw_idx      = '0;
      pw_last_idx = wcnt;
      pw_last_nb  = nb_cl;
      pw_has      = bus.msg_last && !pad_exc;
    end
  end

  keccak_pad_word #(.RATE_WORDS(RATE_WORDS)) u_pad (
    .word     (pw_word),
    .idx      (pw_idx),
    .last_idx (pw_last_idx),
    .last_nb  (pw_last_nb),
    .has_last (pw_has),
    .padded   (pw_out)
  );

  always_ff @(posedge clock) begin
    if (state == FILL && accept)
      blk_buf[wcnt[AW-1:0]] <= bus.msg_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= FILL;
      wcnt           <= '0;
      didx           <= '0;
      last_idx       <= '0;
      last_nb        <= '0;
      blk_last       <= 1'b0;
      need_pad_blk   <= 1'b0;
      bus.msg_ready  <= 1'b0;
      bus.din        <= '0;
      bus.din_valid  <= 1'b0;
      bus.last_block <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          bus.msg_ready <= !closing;
          if (closing) begin
            state          <= DRAIN;
            wcnt           <= '0;
            didx           <= '0;
            last_idx       <= wcnt;
            last_nb        <= nb_cl;
            blk_last       <= bus.msg_last && !pad_exc;
            need_pad_blk   <= pad_exc;
            bus.din        <= pw_out;
            bus.din_valid  <= 1'b1;
            bus.last_block <= bus.msg_last && !pad_exc;
          end else if (accept) begin
            wcnt <= wcnt + CW'(1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (didx == LAST_W) begin
              didx <= '0;
              if (need_pad_blk) begin
                state          <= PADBLK;
                bus.din        <= {24'h0, PAD_FIRST};
                bus.last_block <= 1'b1;
              end else begin
                state          <= FILL;
                bus.msg_ready  <= 1'b1;
                bus.din        <= '0;
                bus.din_valid  <= 1'b0;
                bus.last_block <= 1'b0;
              end
            end else begin
              didx    <= nidx;
              bus.din <= pw_out;
            end
          end
        end
        PADBLK: begin
          if (xfer) begin
            if (didx == LAST_W) begin
              state          <= FILL;
              didx           <= '0;
              need_pad_blk   <= 1'b0;
              bus.msg_ready  <= 1'b1;
              bus.din        <= '0;
              bus.din_valid  <= 1'b0;
              bus.last_block <= 1'b0;
            end else begin
              didx    <= nidx;
              bus.din <= (nidx == LAST_W) ? {PAD_LAST, 24'h0} : '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_padder.sv
// tb/tb_keccak_padder.sv - directed vector bench for keccak_padder
module tb_keccak_padder;
  import pkg_keccak::*;

  localparam int RW = RATE_WORDS;

  logic clock = 1'b0;
  logic reset;
  logic busy;

  keccak_padder_if bus();

  keccak_padder #(.RATE_WORDS(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          nwords;
    logic [2:0]  nb;
    logic [31:0] lastw;
    int          blocks;
    bit          padblk;
    logic [31:0] at_last;
    logic [31:0] after;
    logic [31:0] w33;
  } vec_t;

  vec_t vecs[10];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] msg_data(input int k, input vec_t v);
    if (k == v.nwords - 1) return v.lastw;
    return 32'h5A00_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] exp_word(input vec_t v, input int blk, input int idx);
    int li;
    if (blk < v.blocks - 1) return msg_data(blk * RW + idx, v);
    if (v.padblk) return (idx == 0) ? 32'h0000_0001 : (idx == RW - 1) ? 32'h8000_0000 : 32'h0;
    li = (v.nwords - 1) % RW;
    if (idx == RW - 1) return v.w33;
    if (idx < li) return msg_data(blk * RW + idx, v);
    if (idx == li) return v.at_last;
    if (idx == li + 1) return v.after;
    return 32'h0;
  endfunction

  task automatic send_msg(input vec_t v);
    int t;
    for (int k = 0; k < v.nwords; k++) begin
      @(posedge clock); #1;
      bus.msg_valid  = 1'b1;
      bus.msg_word   = msg_data(k, v);
      bus.msg_last   = (k == v.nwords - 1);
      bus.msg_nbytes = (k == v.nwords - 1) ? v.nb : 3'd0;
      t = 0;
      while (!bus.msg_ready && t < 400) begin
        @(posedge clock); #1;
        t++;
      end
      if (t >= 400) check("msg_ready_timeout", 32'(t), 32'd0);
    end
    @(posedge clock); #1;
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
  endtask

  task automatic collect(input int vi, input vec_t v);
    int total, got, budget, blk, idx;
    logic pv, pbf, plb;
    logic [31:0] pdin;
    total = v.blocks * RW;
    got = 0; budget = 0;
    pv = 1'b0; pbf = 1'b0; plb = 1'b0; pdin = '0;
    while (got < total && budget < 3000) begin
      @(negedge clock);
      budget++;
      if (pv && pbf) begin
        check($sformatf("v%0d hold_din", vi), bus.din, pdin);
        check($sformatf("v%0d hold_valid", vi), 32'(bus.din_valid), 32'd1);
        check($sformatf("v%0d hold_last", vi), 32'(bus.last_block), 32'(plb));
      end
      if (bus.din_valid && !bus.buffer_full) begin
        blk = got / RW;
        idx = got % RW;
        check($sformatf("v%0d b%0d w%0d din", vi, blk, idx), bus.din, exp_word(v, blk, idx));
        check($sformatf("v%0d b%0d w%0d last_block", vi, blk, idx), 32'(bus.last_block),
              32'(blk == v.blocks - 1));
        got++;
      end
      pv = bus.din_valid; pbf = bus.buffer_full; plb = bus.last_block; pdin = bus.din;
    end
    check($sformatf("v%0d xfer_count", vi), 32'(got), 32'(total));
    repeat (3) @(negedge clock);
    check($sformatf("v%0d no_extra_valid", vi), 32'(bus.din_valid), 32'd0);
    check($sformatf("v%0d ready_back", vi), 32'(bus.msg_ready), 32'd1);
    check($sformatf("v%0d idle_busy", vi), 32'(busy), 32'd0);
  endtask

  task automatic do_stall();
    int t;
    t = 0;
    while (!bus.din_valid && t < 400) begin
      @(posedge clock); #1;
      t++;
    end
    repeat (10) @(posedge clock);
    #1 bus.buffer_full = 1'b1;
    repeat (5) @(posedge clock);
    #1 bus.buffer_full = 1'b0;
  endtask

  task automatic run_vec(input int vi, input bit stall);
    vec_t v;
    v = vecs[vi];
    fork
      send_msg(v);
      collect(vi, v);
      begin
        if (stall) do_stall();
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    //          nwords nb  lastw         blks pad at_last       after         w33
    vecs[0] = '{1,  3'd0, 32'hDEADBEEF, 1, 0, 32'h0000_0001, 32'h0,         32'h8000_0000};
    vecs[1] = '{1,  3'd3, 32'hFFCCBBAA, 1, 0, 32'h01CC_BBAA, 32'h0,         32'h8000_0000};
    vecs[2] = '{34, 3'd4, 32'h44332211, 2, 1, 32'h0,         32'h0,         32'h0};
    vecs[3] = '{34, 3'd3, 32'hEE112233, 1, 0, 32'h8111_2233, 32'h0,         32'h8111_2233};
    vecs[4] = '{2,  3'd4, 32'h87654321, 1, 0, 32'h8765_4321, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{3,  3'd7, 32'hCAFEF00D, 1, 0, 32'hCAFE_F00D, 32'h0000_0001, 32'h8000_0000};
    vecs[6] = '{33, 3'd4, 32'h0BADF00D, 1, 0, 32'h0BAD_F00D, 32'h8000_0001, 32'h8000_0001};
    vecs[7] = '{35, 3'd1, 32'h123456AB, 2, 0, 32'h0000_01AB, 32'h0,         32'h8000_0000};
    vecs[8] = '{34, 3'd2, 32'hFFFF5678, 1, 0, 32'h8001_5678, 32'h0,         32'h8001_5678};
    vecs[9] = '{34, 3'd0, 32'h77777777, 1, 0, 32'h8000_0001, 32'h0,         32'h8000_0001};

    reset = 1'b0;
    bus.msg_valid = 1'b0; bus.msg_last = 1'b0; bus.msg_nbytes = 3'd0;
    bus.msg_word = '0; bus.buffer_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst msg_ready", 32'(bus.msg_ready), 32'd0);
    check("rst din", bus.din, 32'd0);
    check("rst din_valid", 32'(bus.din_valid), 32'd0);
    check("rst last_block", 32'(bus.last_block), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", 32'(bus.msg_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(i, i == 3);

    // Reset pulse in the middle of a drain.
    send_msg(vecs[1]);
    t = 0;
    while (!bus.din_valid && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    check("mid_drain_valid", 32'(bus.din_valid), 32'd1);
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_rst din_valid", 32'(bus.din_valid), 32'd0);
    check("mid_rst msg_ready", 32'(bus.msg_ready), 32'd0);
    check("mid_rst din", bus.din, 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    check("mid_rst held", 32'(bus.din_valid), 32'd0);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst ready_rise", 32'(bus.msg_ready), 32'd1);
    check("mid_rst no_emit", 32'(bus.din_valid), 32'd0);
    run_vec(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
